// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - AHB-Lite transfer constants, responder FSM state type and byte-enable helper
//
// Contents:
//   htrans_t  - HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ)
//   hsize_t   - legal HSIZE encodings (byte/halfword/word)
//   hresp_t   - HRESP encodings (OKAY/ERROR)
//   state_t   - responder FSM states (IDLE/DATA/ERR1/ERR2)
//   ahb_be()  - little-endian byte-lane enables for a transfer size and address offset
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_t;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    // Illegal sizes yield no lanes, so a stray call can never corrupt memory.
    function automatic logic [3:0] ahb_be(input logic [2:0] size, input logic [1:0] addr);
        logic [3:0] be;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << addr;
            HSIZE_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: be = 4'b1111;
            default:    be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb_ram_slave.sv
// rtl/ahb_ram_slave.sv - AHB-Lite responder backed by a word-addressed on-chip RAM
//
// Parameters:
//   MEM_WORDS   - RAM depth in 32-bit words (power of two); legal bytes 0 .. MEM_WORDS*4-1
//   WAIT_STATES - HREADYOUT-low cycles inserted in every OKAY data phase (0..15)
// Ports:
//   HCLK, HRESETN            - bus clock, asynchronous active-low reset
//   HSEL, HADDR, HTRANS,
//   HWRITE, HSIZE            - address-phase controls
//   HBURST, HPROT, HMASTLOCK - accepted and ignored
//   HWDATA                   - write data, data phase
//   HREADY                   - bus-level ready, qualifies the address phase
//   HREADYOUT, HRESP, HRDATA - responder outputs
module ahb_ram_slave
    import ahb_pkg::*;
#(
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETN,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic        HMASTLOCK,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int          AW        = $clog2(MEM_WORDS);
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;

    state_t          state, state_next;
    logic [AW+1:0]   addr_q;
    logic            write_q;
    logic [2:0]      size_q;
    logic [3:0]      wait_cnt;

    logic [31:0]     mem [MEM_WORDS];

    logic            sample;
    logic            err_now;
    logic            data_done;
    logic            accept;
    logic            wr_commit;
    logic [AW-1:0]   idx;
    logic [3:0]      be;
    state_t          take_state;

    logic            unused_inputs;
    assign unused_inputs = ^{HTRANS[0], HBURST, HPROT, HMASTLOCK};

    assign sample    = HSEL & HREADY & HTRANS[1];
    assign err_now   = ({1'b0, HADDR} >= MEM_BYTES)
                     || (HSIZE > HSIZE_WORD)
                     || ((HSIZE == HSIZE_HALF) && HADDR[0])
                     || ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00));
    assign data_done = (state == ST_DATA) && (wait_cnt == 4'd0);
    // A new address phase is only taken on a cycle where this slave drives HREADYOUT high.
    assign accept    = sample && ((state == ST_IDLE) || (state == ST_ERR2) || data_done);
    assign wr_commit = data_done && write_q;
    assign idx       = addr_q[AW+1:2];
    assign be        = ahb_be(size_q, addr_q[1:0]);
    assign take_state = err_now ? ST_ERR1 : ST_DATA;

    // State register and address-phase capture.
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state    <= ST_IDLE;
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= 3'd0;
            wait_cnt <= 4'd0;
        end else begin
            state <= state_next;
            if (accept) begin
                addr_q   <= HADDR[AW+1:0];
                write_q  <= HWRITE;
                size_q   <= HSIZE;
                wait_cnt <= 4'(WAIT_STATES);
            end else if ((state == ST_DATA) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_ERR2: state_next = sample ? take_state : ST_IDLE;
            ST_DATA: begin
                if (wait_cnt == 4'd0) begin
                    state_next = sample ? take_state : ST_IDLE;
                end
            end
            ST_ERR1: state_next = ST_ERR2;
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs. Read data is driven straight from the array so it is valid in the
    // completing cycle, including one that immediately follows a committed write.
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        HRDATA    = 32'd0;
        case (state)
            ST_DATA: begin
                HREADYOUT = (wait_cnt == 4'd0);
                if (!write_q) begin
                    HRDATA = mem[idx];
                end
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
            end
            ST_ERR2: HRESP = HRESP_ERROR;
            default: ;
        endcase
    end

    // RAM is deliberately not reset; a write only lands on the completing data-phase edge.
    always_ff @(posedge HCLK) begin
        if (wr_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_ram_slave.sv
// tb/tb_ahb_ram_slave.sv - self-checking bench for ahb_ram_slave with zero and three wait states
module tb_ahb_ram_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hsel, hwrite, hmastlock, sel;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic        ro0, rs0, ro1, rs1;
    logic [31:0] rd0, rd1;
    logic        bus_ready, bus_resp;
    logic [31:0] bus_rdata;

    always #5 clk = ~clk;

    assign bus_ready = sel ? ro1 : ro0;
    assign bus_resp  = sel ? rs1 : rs0;
    assign bus_rdata = sel ? rd1 : rd0;

    ahb_ram_slave #(.MEM_WORDS(1024), .WAIT_STATES(0)) dut0 (
        .HCLK(clk), .HRESETN(rst_n), .HSEL(hsel & ~sel), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HMASTLOCK(hmastlock),
        .HWDATA(hwdata), .HREADY(bus_ready), .HREADYOUT(ro0), .HRESP(rs0), .HRDATA(rd0)
    );

    ahb_ram_slave #(.MEM_WORDS(1024), .WAIT_STATES(3)) dut1 (
        .HCLK(clk), .HRESETN(rst_n), .HSEL(hsel & sel), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HMASTLOCK(hmastlock),
        .HWDATA(hwdata), .HREADY(bus_ready), .HREADYOUT(ro1), .HRESP(rs1), .HRDATA(rd1)
    );

    typedef struct {
        bit          write;
        bit          seq;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          exp_resp;
        logic [31:0] exp_rdata;
        int          exp_cycles;
    } vec_t;

    vec_t        batch[$];
    byte unsigned ref_mem[2][4096];
    int          n_cmp;
    int          n_bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int ws_of(input int s);
        return (s == 1) ? 3 : 0;
    endfunction

    function automatic void push(input bit w, input bit sq, input int sz, input logic [31:0] a,
                                 input logic [31:0] d, input bit er, input logic [31:0] rd,
                                 input int cyc);
        vec_t v;
        v.write = w; v.seq = sq; v.size = 3'(sz); v.addr = a; v.wdata = d;
        v.exp_resp = er; v.exp_rdata = rd; v.exp_cycles = cyc;
        batch.push_back(v);
    endfunction

    // Byte-level memory model: applies every legal write in order and, when fill
    // is set, derives each transfer's expected response from the transfer rules.
    function automatic void model_pass(input int s, input bit fill);
        for (int i = 0; i < batch.size(); i++) begin
            logic [31:0] a;
            logic [31:0] d;
            logic [2:0]  sz;
            bit          err;
            logic [31:0] rd;
            int          nb;
            int          w;
            a  = batch[i].addr;
            d  = batch[i].wdata;
            sz = batch[i].size;
            err = (a >= 32'd4096) || (sz > 3'd2) || (sz == 3'd1 && a[0])
                || (sz == 3'd2 && a[1:0] != 2'b00);
            rd = 32'd0;
            if (!err) begin
                nb = 1 << int'(sz);
                w  = int'(a & 32'h0000_0FFC);
                if (batch[i].write) begin
                    for (int b = 0; b < nb; b++) begin
                        ref_mem[s][int'(a) + b] = d[8*((int'(a) + b) % 4) +: 8];
                    end
                end else begin
                    rd = {ref_mem[s][w+3], ref_mem[s][w+2], ref_mem[s][w+1], ref_mem[s][w]};
                end
            end
            if (fill) begin
                batch[i].exp_resp   = err;
                batch[i].exp_rdata  = rd;
                batch[i].exp_cycles = err ? 2 : 1 + ws_of(s);
            end
        end
    endfunction

    // Pipelined master: issues every queued transfer back to back and records the
    // response and data-phase length of each, then compares against expectations.
    task automatic run_batch(input string tag);
        int          n;
        int          ai;
        int          dp;
        int          cyc;
        int          exp_total;
        int          cycles_q[];
        logic [31:0] rd_q[];
        bit          rs_q[];
        bit          done_q[];
        n = batch.size();
        ai = 0; dp = -1; cyc = 0; exp_total = 1;
        cycles_q = new[n]; rd_q = new[n]; rs_q = new[n]; done_q = new[n];
        for (int i = 0; i < n; i++) begin
            cycles_q[i] = 0; rd_q[i] = 32'd0; rs_q[i] = 1'b0; done_q[i] = 1'b0;
            exp_total += batch[i].exp_cycles;
        end
        while (!(ai == n && dp == -1) && cyc < 4000) begin
            @(posedge clk); #1;
            if (ai < n) begin
                hsel   = 1'b1;
                htrans = batch[ai].seq ? 2'd3 : 2'd2;
                haddr  = batch[ai].addr;
                hwrite = batch[ai].write;
                hsize  = batch[ai].size;
            end else begin
                hsel   = 1'b0;
                htrans = 2'd0;
            end
            hwdata = (dp >= 0) ? batch[dp].wdata : 32'd0;
            @(negedge clk);
            cyc++;
            if (dp >= 0) begin
                cycles_q[dp]++;
                if (bus_ready) begin
                    rd_q[dp] = bus_rdata; rs_q[dp] = bus_resp; done_q[dp] = 1'b1;
                end
            end
            if (bus_ready) begin
                if (ai < n) begin
                    dp = ai; ai++;
                end else begin
                    dp = -1;
                end
            end
        end
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s[%0d] done", tag, i), 32'(done_q[i]), 32'd1);
            check($sformatf("%s[%0d] resp", tag, i), 32'(rs_q[i]), 32'(batch[i].exp_resp));
            check($sformatf("%s[%0d] rdata", tag, i), rd_q[i], batch[i].exp_rdata);
            check($sformatf("%s[%0d] cycles", tag, i), 32'(cycles_q[i]), 32'(batch[i].exp_cycles));
        end
        check($sformatf("%s total cycles", tag), 32'(cyc), 32'(exp_total));
        batch.delete();
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        sel = 1'b0; rst_n = 1'b0;
        hsel = 1'b0; htrans = 2'd0; haddr = 32'd0; hwrite = 1'b0; hsize = 3'd0;
        hburst = 3'd0; hprot = 4'd0; hmastlock = 1'b0; hwdata = 32'd0;

        // Reset values, then release with the bus idle.
        repeat (3) @(negedge clk);
        check("rst ready0", 32'(ro0), 32'd1);
        check("rst resp0", 32'(rs0), 32'd0);
        check("rst rdata0", rd0, 32'd0);
        check("rst ready1", 32'(ro1), 32'd1);
        check("rst resp1", 32'(rs1), 32'd0);
        check("rst rdata1", rd1, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post-rst ready", 32'(bus_ready), 32'd1);
        check("post-rst resp", 32'(bus_resp), 32'd0);
        check("post-rst rdata", bus_rdata, 32'd0);

        // Preload the window used by the tests in both RAMs.
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int w = 0; w < 64; w++) push(1, 0, 2, 32'(w * 4), $urandom, 0, 0, 0);
            push(1, 0, 2, 32'h0000_0FFC, $urandom, 0, 0, 0);
            model_pass(s, 1);
            run_batch($sformatf("preload%0d", s));
        end

        // Zero wait states: directed table.
        sel = 1'b0;
        push(1, 0, 2, 32'h10, 32'hDEAD_BEEF, 0, 32'd0, 1);
        push(0, 0, 2, 32'h10, 32'd0, 0, 32'hDEAD_BEEF, 1);
        push(1, 0, 2, 32'h20, 32'hAABB_CCDD, 0, 32'd0, 1);
        push(1, 0, 0, 32'h21, 32'h0000_1100, 0, 32'd0, 1);
        push(1, 0, 0, 32'h23, 32'h2200_0000, 0, 32'd0, 1);
        push(0, 0, 2, 32'h20, 32'd0, 0, 32'h22BB_11DD, 1);
        push(1, 0, 2, 32'h30, 32'h0102_0304, 0, 32'd0, 1);
        push(1, 0, 1, 32'h32, 32'h5566_0000, 0, 32'd0, 1);
        push(0, 0, 2, 32'h30, 32'd0, 0, 32'h5566_0304, 1);
        push(0, 0, 2, 32'h1002, 32'd0, 1, 32'd0, 2);
        push(0, 0, 2, 32'h11, 32'd0, 1, 32'd0, 2);
        push(0, 0, 3, 32'h14, 32'd0, 1, 32'd0, 2);
        push(1, 0, 1, 32'h15, 32'hFFFF_FFFF, 1, 32'd0, 2);
        push(0, 0, 2, 32'h10, 32'd0, 0, 32'hDEAD_BEEF, 1);
        model_pass(0, 0);
        run_batch("ws0");

        // Three wait states: single read, then a four-beat burst each way.
        sel = 1'b1;
        push(1, 0, 2, 32'h10, 32'h1234_5678, 0, 32'd0, 4);
        push(0, 0, 2, 32'h10, 32'd0, 0, 32'h1234_5678, 4);
        model_pass(1, 0);
        run_batch("ws3 single");
        push(1, 0, 2, 32'h40, 32'hA0A0_0001, 0, 32'd0, 4);
        push(1, 1, 2, 32'h44, 32'hA0A0_0002, 0, 32'd0, 4);
        push(1, 1, 2, 32'h48, 32'hA0A0_0003, 0, 32'd0, 4);
        push(1, 1, 2, 32'h4C, 32'hA0A0_0004, 0, 32'd0, 4);
        model_pass(1, 0);
        run_batch("ws3 wburst");
        push(0, 0, 2, 32'h40, 32'd0, 0, 32'hA0A0_0001, 4);
        push(0, 1, 2, 32'h44, 32'd0, 0, 32'hA0A0_0002, 4);
        push(0, 1, 2, 32'h48, 32'd0, 0, 32'hA0A0_0003, 4);
        push(0, 1, 2, 32'h4C, 32'd0, 0, 32'hA0A0_0004, 4);
        model_pass(1, 0);
        run_batch("ws3 rburst");

        // Errors are two cycles regardless of wait states; the next transfer is taken in ERR2.
        push(1, 0, 2, 32'h0FFC, 32'hCAFE_F00D, 0, 32'd0, 4);
        push(0, 0, 2, 32'h1002, 32'd0, 1, 32'd0, 2);
        push(1, 0, 2, 32'h1000, 32'hFFFF_FFFF, 1, 32'd0, 2);
        push(0, 0, 2, 32'h0FFC, 32'd0, 0, 32'hCAFE_F00D, 4);
        push(0, 0, 2, 32'h40, 32'd0, 0, 32'hA0A0_0001, 4);
        model_pass(1, 0);
        run_batch("ws3 err");

        // Reset during a write wait state discards the write.
        @(posedge clk); #1;
        hsel = 1'b1; htrans = 2'd2; haddr = 32'h40; hwrite = 1'b1; hsize = 3'd2;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'd0; hwdata = 32'h0BAD_0BAD;
        @(negedge clk);
        check("mid-wr wait", 32'(bus_ready), 32'd0);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        check("mid-wr rst ready", 32'(bus_ready), 32'd1);
        check("mid-wr rst resp", 32'(bus_resp), 32'd0);
        check("mid-wr rst rdata", bus_rdata, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1; hwdata = 32'd0;
        push(0, 0, 2, 32'h40, 32'd0, 0, 32'hA0A0_0001, 4);
        model_pass(1, 0);
        run_batch("after rst");

        // Randomized traffic against the model on both wait-state settings.
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int i = 0; i < 40; i++) begin
                logic [31:0] a;
                int          sz;
                a  = ($urandom_range(0, 9) == 0) ? 32'h1000 + $urandom_range(0, 255)
                                                 : 32'($urandom_range(0, 255));
                sz = ($urandom_range(0, 9) == 0) ? int'($urandom_range(3, 7))
                                                 : int'($urandom_range(0, 2));
                push($urandom_range(0, 1), $urandom_range(0, 1), sz, a, $urandom, 0, 0, 0);
            end
            model_pass(s, 1);
            run_batch($sformatf("rand%0d", s));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
